// File: rtl/md_pkg.sv
// md_pkg: shared op encodings, default latencies and state type for the multiply/divide scheduler
package md_pkg;
  typedef enum logic [2:0] {MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_RSVD} md_op_e;
  typedef enum logic {IDLE, RUN} md_state_e;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  function automatic logic is_long_op(input logic [2:0] op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction
endpackage

// File: rtl/md_busy_counter.sv
// md_busy_counter: busy countdown for mult/div with a commit pulse on the final busy cycle
module md_busy_counter
  import md_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         busy_o,
  output logic         commit_o
);
  logic [W-1:0] cnt_q, cnt_d;
  md_state_e st;
  always_comb begin
    st = (cnt_q != '0) ? RUN : IDLE;
    cnt_d = (st == IDLE) ? (load_i ? load_val_i : '0) : cnt_q - W'(1);
    busy_o = st == RUN;
    commit_o = cnt_q == W'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/md_scheduler.sv
// md_scheduler: owns HI/LO, sequences multi-cycle mult/div and raises the MD-class stall
module md_scheduler
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MDUseD,
  output logic        Busy,
  output logic        StallMD,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  logic accept, load, commit, div_op, ovf;
  logic [2:0] op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [31:0] bs, bu, qs, rs, qu, ru;
  logic [63:0] ps, pu;
  assign accept = Start & ~Busy;
  assign load = accept & is_long_op(MDOp);
  assign div_op = MDOp inside {MD_DIV, MD_DIVU};
  assign StallMD = MDUseD & (Busy | (Start & is_long_op(MDOp)));
  assign HI = hi_q;
  assign LO = lo_q;
  md_busy_counter #(.W(CW)) u_cnt (
    .clk       (Clk),
    .rst       (Reset),
    .load_i    (load),
    .load_val_i(div_op ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES)),
    .busy_o    (Busy),
    .commit_o  (commit)
  );
  // Divisor of 1 stands in for zero (result discarded) and for the -1 overflow case,
  // where dividing by 1 yields exactly LO=0x80000000, HI=0.
  always_comb begin
    ps = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    pu = {32'b0, a_q} * {32'b0, b_q};
    ovf = (a_q == 32'h8000_0000) && (b_q == '1);
    bs = ((b_q == '0) || ovf) ? 32'd1 : b_q;
    bu = (b_q == '0) ? 32'd1 : b_q;
    qs = $signed(a_q) / $signed(bs);
    rs = $signed(a_q) % $signed(bs);
    qu = a_q / bu;
    ru = a_q % bu;
    op_d = load ? MDOp : op_q;
    a_d = load ? A : a_q;
    b_d = load ? B : b_q;
    hi_d = (accept && MDOp == MD_MTHI) ? A : hi_q;
    lo_d = (accept && MDOp == MD_MTLO) ? A : lo_q;
    if (commit) begin
      case (op_q)
        MD_MULT:  {hi_d, lo_d} = ps;
        MD_MULTU: {hi_d, lo_d} = pu;
        MD_DIV:   if (b_q != '0) {hi_d, lo_d} = {rs, qs};
        MD_DIVU:  if (b_q != '0) {hi_d, lo_d} = {ru, qu};
        default: ;
      endcase
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
endmodule

// File: tb/tb_md_scheduler.sv
// tb_md_scheduler: directed stimulus with a cycle-numbered reference model and per-cycle compare
module tb_md_scheduler;
  import md_pkg::*;
  localparam int MC = 5;
  localparam int DC = 10;
  logic Clk = 0, Reset = 1, Start = 0, MDUseD = 0;
  logic [2:0] MDOp = 0;
  logic [31:0] A = 0, B = 0;
  logic Busy, StallMD;
  logic [31:0] HI, LO;
  int checks = 0, errors = 0;
  int cyc = 0, busy_until = -1, pend_at = -1;
  logic pend_wr = 0, chk_en = 0;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;

  always #5 Clk = ~Clk;

  md_scheduler dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
    .MDUseD(MDUseD), .Busy(Busy), .StallMD(StallMD), .HI(HI), .LO(LO)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Model: an accepted op at cycle t keeps the unit busy through cycle t+N and its
  // result becomes visible in cycle t+N+1.
  always @(posedge Clk) begin : model
    longint sa, sb, ua, ub, p, q, r;
    if (Reset) begin
      m_hi = 0; m_lo = 0; busy_until = -1; pend_at = -1; chk_en = 1;
    end else begin
      if (pend_at == cyc + 1 && pend_wr) begin m_hi = p_hi; m_lo = p_lo; end
      if (Start && cyc > busy_until) begin
        sa = longint'($signed(A)); sb = longint'($signed(B));
        ua = longint'(A); ub = longint'(B);
        if (MDOp inside {[1:4]}) begin
          busy_until = cyc + (MDOp >= 3 ? DC : MC);
          pend_at = busy_until + 1;
          pend_wr = !(MDOp >= 3 && B == 0);
          if (MDOp == 1) begin p = sa * sb; {p_hi, p_lo} = p; end
          if (MDOp == 2) begin p = ua * ub; {p_hi, p_lo} = p; end
          if (MDOp >= 3 && B != 0) begin
            q = (MDOp == 3) ? sa / sb : ua / ub;
            r = (MDOp == 3) ? sa % sb : ua % ub;
            p_lo = q[31:0]; p_hi = r[31:0];
          end
        end
        if (MDOp == 5) m_hi = A;
        if (MDOp == 6) m_lo = A;
      end
    end
    cyc++;
  end

  always @(negedge Clk) begin : compare
    logic eb;
    if (chk_en) begin
      eb = cyc <= busy_until;
      chk("busy", 32'(Busy), 32'(eb));
      chk("stall", 32'(StallMD), 32'(MDUseD & (eb | (Start & (MDOp inside {[1:4]})))));
      chk("hi", HI, m_hi);
      chk("lo", LO, m_lo);
    end
  end

  task automatic drive(input logic s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic u, input logic r);
    @(posedge Clk);
    #1;
    Start = s; MDOp = op; A = a; B = b; MDUseD = u; Reset = r;
  endtask

  task automatic run_idle(input int n, input logic u, output int bc);
    bc = 0;
    for (int i = 0; i < n; i++) begin
      drive(0, MD_NONE, 0, 0, u, 0);
      @(negedge Clk);
      bc += int'(Busy);
    end
  endtask

  initial begin
    int bc, bc2;
    drive(0, MD_NONE, 0, 0, 0, 1);
    drive(0, MD_NONE, 0, 0, 0, 0);
    @(negedge Clk);
    chk("rst_hi", HI, 0); chk("rst_lo", LO, 0); chk("rst_busy", 32'(Busy), 0); chk("rst_stall", 32'(StallMD), 0);
    drive(1, MD_MULT, 32'hFFFF_FFFF, 2, 1, 0);
    @(negedge Clk);
    chk("mult_stall_start", 32'(StallMD), 1);
    run_idle(6, 1, bc);
    chk("mult_busy_len", bc, MC); chk("mult_hi", HI, 32'hFFFF_FFFF); chk("mult_lo", LO, 32'hFFFF_FFFE);
    drive(1, MD_MULTU, 32'hFFFF_FFFF, 2, 0, 0);
    @(negedge Clk);
    chk("multu_stall_start", 32'(StallMD), 0);
    run_idle(6, 0, bc);
    chk("multu_busy_len", bc, MC); chk("multu_hi", HI, 32'h1); chk("multu_lo", LO, 32'hFFFF_FFFE);
    drive(1, MD_DIV, 32'hFFFF_FFF9, 2, 0, 0);
    run_idle(11, 0, bc);
    chk("div_busy_len", bc, DC); chk("div_hi", HI, 32'hFFFF_FFFF); chk("div_lo", LO, 32'hFFFF_FFFD);
    drive(1, MD_DIVU, 7, 0, 0, 0);
    run_idle(11, 0, bc);
    chk("divz_busy_len", bc, DC); chk("divz_hi", HI, 32'hFFFF_FFFF); chk("divz_lo", LO, 32'hFFFF_FFFD);
    drive(1, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_idle(11, 0, bc);
    chk("ovf_hi", HI, 0); chk("ovf_lo", LO, 32'h8000_0000);
    drive(1, MD_MULT, 3, 4, 1, 0);
    drive(1, MD_DIV, 100, 7, 1, 0);
    @(negedge Clk);
    bc = int'(Busy);
    run_idle(5, 1, bc2);
    chk("ign_busy_len", bc + bc2, MC); chk("ign_hi", HI, 0); chk("ign_lo", LO, 12);
    drive(1, MD_MULT, 32'hFFFF_FFFE, 3, 1, 0);
    run_idle(5, 1, bc);
    drive(1, MD_MULTU, 5, 6, 1, 0);
    @(negedge Clk);
    chk("b2b_busy", 32'(Busy), 0); chk("b2b_hi", HI, 32'hFFFF_FFFF); chk("b2b_lo", LO, 32'hFFFF_FFFA);
    run_idle(6, 1, bc);
    chk("b2b_busy_len", bc, MC); chk("b2b_lo2", LO, 30);
    drive(1, MD_DIV, 100, 7, 0, 0);
    run_idle(2, 0, bc);
    drive(0, MD_NONE, 0, 0, 0, 1);
    @(negedge Clk);
    chk("midrst_busy_before", 32'(Busy), 1);
    run_idle(12, 0, bc);
    chk("midrst_busy_len", bc, 0); chk("midrst_hi", HI, 0); chk("midrst_lo", LO, 0);
    drive(1, MD_MTHI, 32'h1234_5678, 0, 1, 0);
    drive(1, MD_MTLO, 32'h9ABC_DEF0, 0, 1, 0);
    @(negedge Clk);
    chk("mthi_hi", HI, 32'h1234_5678); chk("mthi_lo", LO, 0);
    drive(0, MD_NONE, 0, 0, 1, 0);
    @(negedge Clk);
    chk("mtlo_lo", LO, 32'h9ABC_DEF0); chk("mtlo_busy", 32'(Busy), 0);
    drive(1, MD_NONE, 32'h55, 32'h66, 1, 0);
    drive(1, MD_RSVD, 32'h77, 1, 1, 0);
    run_idle(2, 0, bc);
    chk("nop_busy_len", bc, 0); chk("nop_hi", HI, 32'h1234_5678); chk("nop_lo", LO, 32'h9ABC_DEF0);
    drive(1, MD_MULT, 2, 3, 1, 1);
    run_idle(7, 0, bc);
    chk("rst_start_busy_len", bc, 0); chk("rst_start_hi", HI, 0); chk("rst_start_lo", LO, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/md_scheduler.md
# md_scheduler

Multiply/divide scheduler for the five-stage pipeline. Owns the HI/LO registers and the multi-cycle mult/div busy sequence. Accepts operations from the E stage and generates the stall request that holds any MD-class instruction in D while the unit is occupied. It sits beside the E-stage ALU and consumes the decode stage's `MD` flag together with forwarded E-stage operands.

## Interface

**Parameters**
- `MULT_CYCLES`, default 5 — busy cycles for mult/multu (≥1)
- `DIV_CYCLES`, default 10 — busy cycles for div/divu (≥1)

**Ports**
- `Clk` in 1 — clock, rising edge
- `Reset` in 1 — synchronous, active-high. One clock; sampled on the rising edge of `Clk`.
- `Start` in 1 — E-stage instruction is an MD operation this cycle
- `MDOp` in 3 — operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved
- `A` in 32 — forwarded rs value (E stage)
- `B` in 32 — forwarded rt value (E stage)
- `MDUseD` in 1 — instruction in D is MD-class (mult/div/mthi/mtlo/mfhi/mflo)
- `Busy` out 1 — a mult/div is in progress
- `StallMD` out 1 — stall request to the hazard unit
- `HI` out 32 — HI register, used for mfhi
- `LO` out 32 — LO register, used for mflo

## Operation

**State**
- `IDLE`: count == 0, `Busy` = 0.
- `RUN`: count > 0, `Busy` = 1.

**Accepting an operation**
- An operation is accepted only when `Start` = 1 and the unit is in `IDLE`.
- `Start` asserted in `RUN` is ignored: no state change, no HI/LO write. The hazard unit never allows this; the bench checks it as a protection case.

**mult/multu/div/divu**
- On acceptance, `A` and `B` are latched into operand registers, the op is latched, and count loads `MULT_CYCLES` or `DIV_CYCLES`.
- In `RUN`, count decrements each cycle.
- On the edge where count == 1, the result is committed and count becomes 0.

**Result rules**
- mult: {HI,LO} = signed 64-bit product.
- multu: {HI,LO} = unsigned 64-bit product.
- div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
- divu: unsigned quotient and remainder.
- Divide by zero (B == 0) for div/divu: still consumes `DIV_CYCLES` busy cycles, and HI/LO keep their prior values.
- Signed overflow (0x80000000 / -1): LO = 0x80000000, HI = 0.

**mthi/mtlo**
- On acceptance in `IDLE`, HI or LO is written with `A` at the next edge.
- There is no busy period, so the unit stays in `IDLE`.

**Other codes**
- `MDOp` 0 or 7 with `Start`: no effect.

**Stall**
- `StallMD` = `MDUseD` & (`Busy` | (`Start` & `MDOp` ∈ {1..4})).
- This is combinational from the inputs and the current state.

**Reset**
- Takes effect on the next edge regardless of state, including mid-operation: count = 0, HI = 0, LO = 0, operand registers = 0, `Busy` = 0.
- A pending result is discarded.
- `StallMD` is 0 when `Busy` = 0 and `Start` = 0.

## Timing

- `Start` with mult at cycle t: `Busy` = 1 in cycles t+1 .. t+`MULT_CYCLES`.
  - HI/LO hold the new value from cycle t+`MULT_CYCLES`+1.
  - `Busy` = 0 in that same cycle.
- A back-to-back `Start` is accepted in the first cycle where `Busy` = 0. There is no dead cycle.
- mthi/mtlo at cycle t: new value visible in cycle t+1.
- `HI` and `LO` are registered outputs, with no combinational bypass. An mfhi in E at cycle t+1 after mthi at t reads the updated value.
- `Start` & `Reset` in the same cycle: reset wins.

## Structure

- Package `md_pkg` holds:
  - the `MDOp` encodings (`MD_NONE` .. `MD_MTLO`)
  - default latencies
  - the state enum {`IDLE`, `RUN`}
- Sub-module `md_busy_counter` holds the count register, load/decrement logic, and the `Busy`/commit-pulse outputs. It is parameterised by width ⌈log2(max(MULT_CYCLES, DIV_CYCLES)+1)⌉.
- Arithmetic (64-bit multiply, 32-bit divide) sits in the top level, computed from the latched operands at commit.

## Test plan

- Reset, then mult with A=0xFFFFFFFF, B=2:
  - `Busy` high for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - multu with the same operands gives HI=0x00000001, LO=0xFFFFFFFE.
- div with A=-7 (0xFFFFFFF9), B=2:
  - After 10 busy cycles, LO=0xFFFFFFFD and HI=0xFFFFFFFF.
  - divu 7/0 leaves HI/LO unchanged after 10 busy cycles.
- mult in progress with `MDUseD`=1:
  - `StallMD`=1 in the `Start` cycle and every busy cycle, 0 in the cycle `Busy` falls.
  - With `MDUseD`=0, `StallMD` stays 0 throughout.
- `Start`/div issued while `Busy`: ignored.
  - The original result commits on schedule.
  - The count is not reloaded.
- `Reset` asserted in the 3rd busy cycle of a div: next cycle `Busy`=0, HI=LO=0, and no later commit occurs.
- mthi A=0x12345678 then mtlo A=0x9ABCDEF0 on consecutive cycles:
  - HI and LO update one cycle after each.
  - `Busy` never asserts.
